// File: rtl/noc_pkg.sv
// Shared types for the router output-port logic.
// Holds the default flit width, the flit type and the arbiter state encoding.
package noc_pkg;

   // Default flit width used by routers that do not override it.
   localparam int FLIT_W = 16;

   // One flit of payload as seen on a router link.
   typedef logic [FLIT_W-1:0] flit_t;

   // Output-port ownership state.
   // IDLE means the port is free for arbitration.
   // LOCKED means a packet has won the port and keeps it until its tail flit.
   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational rotating-priority arbiter.
// The requester at index ptr_i has the highest priority. Priority then falls
// through the higher indices and wraps back to index 0. The grant is one-hot,
// or all zero when nobody requests. There is no state here, so the same block
// can serve every output port of the router.
module noc_rr_arbiter #(
   parameter int NUM_IN = 5,
   parameter int PTR_W  = $clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0] req_i,
   input  logic [PTR_W-1:0]  ptr_i,
   output logic [NUM_IN-1:0] grant_o
);

   logic found;

   // Scan upward from the pointer first, then wrap around to the indices below it.
   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (!found && req_i[i] && (i >= int'(ptr_i))) begin
            grant_o[i] = 1'b1;
            found      = 1'b1;
         end
      end
      for (int i = 0; i < NUM_IN; i++) begin
         if (!found && req_i[i] && (i < int'(ptr_i))) begin
            grant_o[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/noc_output_arbiter.sv
// Router output-port arbiter.
// NUM_IN input ports share one output link. Arbitration works per packet
// (wormhole): a head flit that wins locks the port to its requester until that
// requester's tail flit is accepted. A flit is issued only when a downstream
// credit is available. Accepted flits leave through a single output register,
// so each one reaches the link one cycle after it is accepted.
module noc_output_arbiter #(
   parameter int NUM_IN  = 5,
   parameter int FLIT_W  = noc_pkg::FLIT_W,
   parameter int CREDITS = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_IN-1:0]            req_i,
   input  logic [NUM_IN-1:0]            tail_i,
   input  logic [NUM_IN*FLIT_W-1:0]     flit_i,
   input  logic                         inc_credit_i,
   output logic [NUM_IN-1:0]            grant_o,
   output logic [FLIT_W-1:0]            data_o,
   output logic                         send_data_o,
   output logic [$clog2(CREDITS+1)-1:0] credit_cnt_o,
   output logic                         locked_o,
   output logic                         err_o
);

   import noc_pkg::arb_state_e;
   import noc_pkg::IDLE;
   import noc_pkg::LOCKED;

   localparam int PTR_W = $clog2(NUM_IN);
   localparam int CNT_W = $clog2(CREDITS + 1);
   localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDITS);

   // Ownership FSM, round-robin pointer and packet owner.
   arb_state_e        state_q, state_d;
   logic [PTR_W-1:0]  ptr_q,   ptr_d;
   logic [PTR_W-1:0]  owner_q, owner_d;

   // Downstream credit tracking.
   logic [CNT_W-1:0]  credit_q, credit_d;
   logic              err_q,    err_d;

   // Output register stage.
   logic [FLIT_W-1:0] data_q,   data_d;
   logic              send_q,   send_d;

   // Grant path.
   logic [NUM_IN-1:0] arb_grant;
   logic [NUM_IN-1:0] owner_oh;
   logic [NUM_IN-1:0] grant;
   logic              credit_ok;
   logic              accept;
   logic              accept_tail;
   logic [PTR_W-1:0]  acc_idx;

   // Pointer advance with wrap at NUM_IN-1, so NUM_IN need not be a power of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] n;
      if (int'(p) >= NUM_IN - 1) begin
         n = '0;
      end else begin
         n = p + PTR_W'(1);
      end
      return n;
   endfunction

   noc_rr_arbiter #(
      .NUM_IN (NUM_IN),
      .PTR_W  (PTR_W)
   ) u_rr_arbiter (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .grant_o (arb_grant)
   );

   // Pick who is accepted this cycle: the owner while locked, otherwise the arbiter winner, and nobody without credit.
   always_comb begin
      owner_oh = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         owner_oh[i] = (int'(owner_q) == i);
      end

      credit_ok = (credit_q != '0);

      if (!credit_ok) begin
         grant = '0;
      end else if (state_q == LOCKED) begin
         grant = owner_oh & req_i;
      end else begin
         grant = arb_grant;
      end

      accept      = |grant;
      accept_tail = |(grant & tail_i);

      acc_idx = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant[i]) begin
            acc_idx = PTR_W'(i);
         end
      end
   end

   // Ownership FSM: a head flit without tail locks the port, the owner's tail releases it and moves the pointer past the owner.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (accept_tail) begin
                  ptr_d = next_ptr(acc_idx);
               end else begin
                  state_d = LOCKED;
                  owner_d = acc_idx;
               end
            end
         end
         LOCKED: begin
            if (accept && accept_tail) begin
               state_d = IDLE;
               ptr_d   = next_ptr(owner_q);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Credit counter: an accept spends one credit, a return pulse gives one back, and a return while already full is flagged as an overflow.
   always_comb begin
      credit_d = credit_q;
      err_d    = err_q;
      if (accept && !inc_credit_i) begin
         credit_d = credit_q - CNT_W'(1);
      end else if (!accept && inc_credit_i) begin
         if (credit_q == CREDIT_MAX) begin
            err_d = 1'b1;
         end else begin
            credit_d = credit_q + CNT_W'(1);
         end
      end
   end

   // Output mux: capture the accepted flit, and hold the last one when nothing is sent.
   always_comb begin
      send_d = accept;
      data_d = data_q;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant[i]) begin
            data_d = flit_i[i*FLIT_W +: FLIT_W];
         end
      end
   end

   // State, credit and output registers; reset abandons any packet in flight and refills the credits.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         owner_q  <= '0;
         credit_q <= CREDIT_MAX;
         err_q    <= 1'b0;
         data_q   <= '0;
         send_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         credit_q <= credit_d;
         err_q    <= err_d;
         data_q   <= data_d;
         send_q   <= send_d;
      end
   end

   assign grant_o      = grant;
   assign data_o       = data_q;
   assign send_data_o  = send_q;
   assign credit_cnt_o = credit_q;
   assign locked_o     = (state_q == LOCKED);
   assign err_o        = err_q;

endmodule
